// File: rtl/ysyx_24080006_axi_rd_slave.sv
// AXI4 read-only responder for the instruction-fetch path.
// Serves FIXED/INCR/WRAP bursts from a word-wide synchronous memory with a fixed first-beat latency.
module ysyx_24080006_axi_rd_slave #(
  parameter logic [31:0] BASE_ADDR = 32'ha000_0000,
  parameter int          ADDR_W    = 20,
  parameter int          LATENCY   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic [3:0]        rid,
  output logic              mem_re,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [ADDR_W-3:0] word_index(input logic [31:0] addr);
    return (ADDR_W-2)'((addr - BASE_ADDR) >> 2);
  endfunction

  // WRAP container is (len+1) words; its byte mask is 4*len+3 because the low two bits are always zero.
  function automatic logic [31:0] beat_advance(input logic [31:0] addr, input logic [1:0] burst,
                                               input logic [7:0] len);
    logic [31:0] mask;
    mask = ({24'd0, len} << 2) | 32'd3;
    case (burst)
      2'b01:   beat_advance = addr + 32'd4;
      2'b10:   beat_advance = (addr & ~mask) | ((addr + 32'd4) & mask);
      default: beat_advance = addr;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [31:0] addr, input logic [2:0] size,
                                          input logic [1:0] burst, input logic [7:0] len);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if ((addr < BASE_ADDR) || ((off >> ADDR_W) != 32'd0)) begin
      classify = RESP_DECERR;
    end else if ((size != 3'h2) || (burst == 2'b11) ||
                 ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))) begin
      classify = RESP_SLVERR;
    end else begin
      classify = RESP_OKAY;
    end
  endfunction

  logic [1:0]  state_r;
  logic [31:0] addr_r;
  logic [3:0]  id_r;
  logic [7:0]  len_r;
  logic [1:0]  burst_r;
  logic [1:0]  err_r;
  logic [7:0]  beat_r;
  logic [3:0]  wait_cnt_r;
  logic [31:0] rdata_r;
  logic        cap_pend_r;

  logic        ar_fire_s;
  logic        r_fire_s;
  logic [31:0] start_addr_s;
  logic [1:0]  start_err_s;
  logic [31:0] next_addr_s;

  assign arready      = (state_r == S_IDLE) && !reset;
  assign ar_fire_s    = arvalid && arready;
  assign r_fire_s     = rvalid && rready;
  assign start_addr_s = {araddr[31:2], 2'b00};
  assign start_err_s  = classify(araddr, arsize, arburst, arlen);
  assign next_addr_s  = beat_advance(addr_r, burst_r, len_r);

  // Memory data arrives in the first RESP cycle; it is forwarded then and held in rdata_r afterwards.
  assign rdata = cap_pend_r ? mem_rdata : rdata_r;

  // Burst sequencer: capture, wait states, one memory read per beat, held R beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      addr_r     <= 32'd0;
      id_r       <= 4'd0;
      len_r      <= 8'd0;
      burst_r    <= 2'b00;
      err_r      <= RESP_OKAY;
      beat_r     <= 8'd0;
      wait_cnt_r <= 4'd0;
      rdata_r    <= 32'd0;
      cap_pend_r <= 1'b0;
      rvalid     <= 1'b0;
      rresp      <= RESP_OKAY;
      rlast      <= 1'b0;
      rid        <= 4'd0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ar_fire_s) begin
            addr_r  <= start_addr_s;
            id_r    <= arid;
            len_r   <= arlen;
            burst_r <= arburst;
            err_r   <= start_err_s;
            beat_r  <= 8'd0;
            if (LATENCY > 0) begin
              state_r    <= S_WAIT;
              wait_cnt_r <= 4'(LATENCY - 1);
            end else begin
              state_r  <= S_READ;
              mem_re   <= (start_err_s == RESP_OKAY);
              mem_addr <= word_index(start_addr_s);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r  <= S_READ;
            mem_re   <= (err_r == RESP_OKAY);
            mem_addr <= word_index(addr_r);
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        S_READ: begin
          mem_re     <= 1'b0;
          state_r    <= S_RESP;
          rvalid     <= 1'b1;
          rlast      <= (beat_r == len_r);
          rresp      <= err_r;
          rid        <= id_r;
          rdata_r    <= 32'd0;
          cap_pend_r <= (err_r == RESP_OKAY);
        end
        S_RESP: begin
          if (cap_pend_r) begin
            rdata_r    <= mem_rdata;
            cap_pend_r <= 1'b0;
          end
          if (r_fire_s) begin
            rvalid <= 1'b0;
            if (rlast) begin
              state_r <= S_IDLE;
            end else begin
              state_r  <= S_READ;
              addr_r   <= next_addr_s;
              beat_r   <= beat_r + 8'd1;
              mem_re   <= (err_r == RESP_OKAY);
              mem_addr <= word_index(next_addr_s);
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_axi_rd_slave.sv
// Randomized bench for the fetch-side AXI read responder, checked against a burst-level reference model.
`timescale 1ns/1ps
module tb_ysyx_24080006_axi_rd_slave;

  localparam logic [31:0] BASE = 32'ha000_0000;
  localparam int          AW   = 20;
  localparam int          LAT  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   araddr = 32'd0;
  logic [3:0]    arid = 4'd0;
  logic [7:0]    arlen = 8'd0;
  logic [2:0]    arsize = 3'd2;
  logic [1:0]    arburst = 2'b01;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [3:0]    rid;
  logic          mem_re;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_rdata = 32'd0;

  int n_checks = 0;
  int n_errors = 0;
  int mem_re_total = 0;

  always #5 clock = ~clock;

  ysyx_24080006_axi_rd_slave #(.BASE_ADDR(BASE), .ADDR_W(AW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Synchronous memory: data the cycle after a read, garbage otherwise so held beats cannot lean on it.
  always @(posedge clock) begin
    if (mem_re) begin
      mem_rdata    <= mem_word(32'(mem_addr));
      mem_re_total <= mem_re_total + 1;
    end else begin
      mem_rdata <= $urandom;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [1:0] bt, input logic [7:0] len);
    if (64'(a) < 64'(BASE) || 64'(a) >= 64'(BASE) + (64'd1 << AW)) return 2'b11;
    if (size != 3'd2 || bt == 2'b11) return 2'b10;
    if (bt == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] a, input logic [1:0] bt,
                                           input logic [7:0] len, input int i);
    logic [31:0] w, c, cb;
    w  = a & 32'hFFFF_FFFC;
    c  = (32'(len) + 32'd1) * 32'd4;
    cb = w - (w % c);
    case (bt)
      2'b01:   return w + 32'(4 * i);
      2'b10:   return cb + (((w - cb) + 32'(4 * i)) % c);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] addr);
    return mem_word(((addr - BASE) & ((32'd1 << AW) - 32'd1)) >> 2);
  endfunction

  // mode: 0 ready at once, 1 ready one cycle late, 2 random delay. abort_after>0 resets after that many beats.
  task automatic run_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt, input int mode,
                           input int abort_after);
    logic [1:0]  er;
    logic [31:0] ed;
    int w, d, mre0;
    er = ref_resp(a, size, bt, len);
    @(negedge clock);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = bt;
    w = 0;
    while (!arready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check_eq("ar_ready", 32'(arready), 32'd1);
    mre0 = mem_re_total;
    @(negedge clock);
    arvalid = 1'b0; araddr = $urandom; arid = 4'($urandom); arlen = 8'($urandom);
    arsize = 3'($urandom); arburst = 2'($urandom);
    w = 1;
    while (!rvalid && w < 40) begin
      @(negedge clock);
      w++;
    end
    check_eq("first_lat", 32'(w), 32'(2 + LAT));
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) begin
        check_eq("r_drop", 32'(rvalid), 32'd0);
        w = 1;
        while (!rvalid && w < 40) begin
          @(negedge clock);
          w++;
        end
        check_eq("beat_gap", 32'(w), 32'd2);
      end
      ed = (er == 2'b00) ? ref_data(ref_addr(a, bt, len, i)) : 32'd0;
      d = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
      rready = (d == 0);
      for (int k = 0; k <= d; k++) begin
        if (k > 0) @(negedge clock);
        check_eq($sformatf("rvalid b%0d k%0d", i, k), 32'(rvalid), 32'd1);
        check_eq($sformatf("rdata b%0d k%0d", i, k), rdata, ed);
        check_eq($sformatf("rmeta b%0d k%0d", i, k), 32'({rid, rresp, rlast}),
                 32'({id, er, (i == int'(len))}));
        if (k == d) rready = 1'b1;
      end
      @(negedge clock);
      rready = 1'b0;
      if (abort_after == i + 1) begin
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_mem_re", 32'(mem_re), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_rel_arready", 32'(arready), 32'd1);
        repeat (4) begin
          @(negedge clock);
          check_eq("rst_quiet", 32'(rvalid), 32'd0);
        end
        return;
      end
    end
    check_eq("r_idle", 32'(rvalid), 32'd0);
    check_eq("ar_ready_after", 32'(arready), 32'd1);
    check_eq("mem_re_cnt", 32'(mem_re_total - mre0), (er == 2'b00) ? 32'(len) + 32'd1 : 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  b;
    logic [2:0]  s;
    repeat (3) @(negedge clock);
    check_eq("rst_arready0", 32'(arready), 32'd0);
    check_eq("rst_rvalid0", 32'(rvalid), 32'd0);
    check_eq("rst_rlast0", 32'(rlast), 32'd0);
    check_eq("rst_rresp0", 32'(rresp), 32'd0);
    check_eq("rst_rdata0", rdata, 32'd0);
    check_eq("rst_rid0", 32'(rid), 32'd0);
    check_eq("rst_mem_re0", 32'(mem_re), 32'd0);
    check_eq("rst_mem_addr0", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rel_arready", 32'(arready), 32'd1);

    run_burst(32'ha000_0014, 4'h5, 8'd7, 3'd2, 2'b10, 0, 0);
    run_burst(32'ha000_0100, 4'h3, 8'd0, 3'd2, 2'b01, 0, 0);
    run_burst(32'ha000_0014, 4'h9, 8'd7, 3'd2, 2'b10, 1, 0);
    run_burst(32'h3000_0000, 4'h1, 8'd3, 3'd2, 2'b01, 0, 0);
    run_burst(32'ha010_0000, 4'hc, 8'd0, 3'd2, 2'b01, 1, 0);
    run_burst(32'ha000_0040, 4'h2, 8'd0, 3'd1, 2'b01, 0, 0);
    run_burst(32'ha000_0040, 4'h4, 8'd2, 3'd2, 2'b10, 2, 0);
    run_burst(32'ha00f_fff8, 4'h6, 8'd3, 3'd2, 2'b01, 2, 0);
    run_burst(32'ha000_0203, 4'h7, 8'd3, 3'd2, 2'b00, 1, 0);
    run_burst(32'ha000_0000, 4'h8, 8'd0, 3'd2, 2'b11, 0, 0);
    run_burst(32'ha000_1000, 4'ha, 8'd7, 3'd2, 2'b01, 0, 3);
    run_burst(32'ha000_1000, 4'hb, 8'd7, 3'd2, 2'b01, 0, 0);

    for (int n = 0; n < 40; n++) begin
      a = BASE + ($urandom & 32'h000F_FFFF);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      b = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) b = 2'b11;
      case ($urandom_range(0, 4))
        0:       l = 8'd0;
        1:       l = 8'd1;
        2:       l = 8'd3;
        3:       l = 8'd7;
        default: l = 8'($urandom_range(0, 15));
      endcase
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      run_burst(a, 4'($urandom), l, s, b, $urandom_range(0, 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
